// File: rtl/note_scan_scheduler.sv
// Scans the five pitch bins through one shared correlator per frame and publishes the scores.
// Optional NOTE_SCAN_HOLD_EN: captures go to a shadow bank and all five scores update together.
module note_scan_scheduler #(
  parameter int SCORE_W = 36,
  parameter int LAG_W   = 10,
  parameter int LAG_C   = 184,
  parameter int LAG_D   = 164,
  parameter int LAG_E   = 146,
  parameter int LAG_G   = 122,
  parameter int LAG_A   = 109,
  parameter int TIMEOUT = 4095
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  output logic                      corr_start,
  output logic [2:0]                corr_sel,
  output logic [LAG_W-1:0]          corr_lag,
  input  logic                      corr_done,
  input  logic signed [SCORE_W-1:0] corr_result,
  output logic signed [SCORE_W-1:0] score_c,
  output logic signed [SCORE_W-1:0] score_d,
  output logic signed [SCORE_W-1:0] score_e,
  output logic signed [SCORE_W-1:0] score_g,
  output logic signed [SCORE_W-1:0] score_a,
  output logic                      scores_valid,
  output logic                      busy,
  output logic                      frame_overrun,
  output logic                      timeout_flag
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  function automatic logic [LAG_W-1:0] lag_of(input logic [2:0] idx);
    case (idx)
      3'd0:    lag_of = LAG_W'(LAG_C);
      3'd1:    lag_of = LAG_W'(LAG_D);
      3'd2:    lag_of = LAG_W'(LAG_E);
      3'd3:    lag_of = LAG_W'(LAG_G);
      default: lag_of = LAG_W'(LAG_A);
    endcase
  endfunction

  state_t                      r_state;
  logic [2:0]                  r_idx;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_start;
  logic [2:0]                  r_sel;
  logic [LAG_W-1:0]            r_lag;
  logic                        r_valid;
  logic                        r_busy;
  logic                        r_overrun;
  logic                        r_timeout;
  logic signed [SCORE_W-1:0]   r_score [5];
`ifdef NOTE_SCAN_HOLD_EN
  logic signed [SCORE_W-1:0]   r_shadow [5];
`endif

  logic                        w_hit;
  logic signed [SCORE_W-1:0]   w_cap;
  logic [2:0]                  w_next_idx;

  // A missing answer is recorded as the most negative score (note inactive)
  assign w_hit      = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_cap      = corr_done ? corr_result : MOST_NEG;
  assign w_next_idx = r_idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 3'd0;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_sel     <= 3'd0;
      r_lag     <= LAG_W'(LAG_C);
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_score[i] <= MOST_NEG;
`ifdef NOTE_SCAN_HOLD_EN
        r_shadow[i] <= MOST_NEG;
`endif
      end
    end else begin
      r_start   <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= frame_start & r_busy;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state <= S_ISSUE;
            r_idx   <= 3'd0;
            r_sel   <= 3'd0;
            r_lag   <= lag_of(3'd0);
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (corr_done | w_hit) begin
            if (!corr_done) r_timeout <= 1'b1;
`ifdef NOTE_SCAN_HOLD_EN
            r_shadow[r_idx] <= w_cap;
            if (r_idx == 3'd4) begin
              for (int i = 0; i < 4; i++) r_score[i] <= r_shadow[i];
              r_score[4] <= w_cap;
            end
`else
            r_score[r_idx] <= w_cap;
`endif
            if (r_idx == 3'd4) begin
              r_state <= S_DONE;
              r_valid <= 1'b1;
            end else begin
              r_idx   <= w_next_idx;
              r_sel   <= w_next_idx;
              r_lag   <= lag_of(w_next_idx);
              r_start <= 1'b1;
              r_state <= S_ISSUE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign corr_start    = r_start;
  assign corr_sel      = r_sel;
  assign corr_lag      = r_lag;
  assign scores_valid  = r_valid;
  assign busy          = r_busy;
  assign frame_overrun = r_overrun;
  assign timeout_flag  = r_timeout;
  assign score_c       = r_score[0];
  assign score_d       = r_score[1];
  assign score_e       = r_score[2];
  assign score_g       = r_score[3];
  assign score_a       = r_score[4];

endmodule

// File: tb/tb_note_scan_scheduler.sv
// Directed bench for note_scan_scheduler: scan order, timeouts, overrun, reset, ignored strobes, publish timing.
module tb_note_scan_scheduler;

  localparam logic signed [35:0] MOST_NEG = 36'sh800000000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                frame_start = 1'b0;
  logic                corr_start;
  logic [2:0]          corr_sel;
  logic [9:0]          corr_lag;
  logic                corr_done = 1'b0;
  logic signed [35:0]  corr_result = '0;
  logic signed [35:0]  score_c, score_d, score_e, score_g, score_a;
  logic                scores_valid, busy, frame_overrun, timeout_flag;

  note_scan_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .corr_start(corr_start), .corr_sel(corr_sel), .corr_lag(corr_lag),
    .corr_done(corr_done), .corr_result(corr_result),
    .score_c(score_c), .score_d(score_d), .score_e(score_e),
    .score_g(score_g), .score_a(score_a),
    .scores_valid(scores_valid), .busy(busy),
    .frame_overrun(frame_overrun), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  logic signed [35:0] sc [5];
  assign sc[0] = score_c;
  assign sc[1] = score_d;
  assign sc[2] = score_e;
  assign sc[3] = score_g;
  assign sc[4] = score_a;

  int n_pass = 0;
  int n_total = 0;

  int exp_lag [5] = '{184, 164, 146, 122, 109};

  // Correlator model controls and per-frame observations
  logic signed [35:0] resp_val [5];
  int                 resp_dly;
  int                 ofs_at;
  bit                 coinc;
  int                 start_cyc [8];
  logic [2:0]         got_sel [8];
  logic [9:0]         got_lag [8];
  int                 n_start, n_valid, n_ovr, valid_cyc, ovr_cyc;
  logic signed [35:0] mid_c, mid_a;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_resp(input int v0, input int v1, input int v2, input int v3, input int v4);
    resp_val[0] = 36'(v0);
    resp_val[1] = 36'(v1);
    resp_val[2] = 36'(v2);
    resp_val[3] = 36'(v3);
    resp_val[4] = 36'(v4);
  endtask

  task automatic run_frame;
    int due;
    due = -1;
    n_start = 0; n_valid = 0; n_ovr = 0; valid_cyc = -1; ovr_cyc = -1;
    frame_start = 1'b1;
    for (int cyc = 1; cyc < 25000; cyc++) begin
      tick();
      frame_start = 1'b0;
      corr_done   = 1'b0;
      corr_result = '0;
      if (corr_start) begin
        if (n_start < 8) begin
          got_sel[n_start]   = corr_sel;
          got_lag[n_start]   = corr_lag;
          start_cyc[n_start] = cyc;
        end
        if (n_start == 1) begin
          mid_c = score_c;
          mid_a = score_a;
        end
        n_start++;
        if (resp_dly > 0) due = cyc + resp_dly;
        if (coinc) begin
          corr_done   = 1'b1;
          corr_result = 36'sd777;
        end
      end
      if (scores_valid) begin
        n_valid++;
        if (valid_cyc < 0) valid_cyc = cyc;
      end
      if (frame_overrun) begin
        n_ovr++;
        ovr_cyc = cyc;
      end
      if (cyc == due && n_start >= 1 && n_start <= 5) begin
        corr_done   = 1'b1;
        corr_result = resp_val[n_start-1];
      end
      if (cyc == ofs_at) frame_start = 1'b1;
      if (valid_cyc >= 0 && cyc >= valid_cyc + 3) break;
    end
    frame_start = 1'b0;
    corr_done   = 1'b0;
    n_total++;
    if (valid_cyc < 0) $display("FAIL frame_timeout: scores_valid never seen, required within 25000 cycles");
    else n_pass++;
  endtask

  task automatic test_reset;
    tick(); tick();
    n_total++;
    if ({corr_start, scores_valid, busy, frame_overrun, timeout_flag, corr_sel} !== 8'd0)
      $display("FAIL reset_ctrl: got %b required 00000000",
               {corr_start, scores_valid, busy, frame_overrun, timeout_flag, corr_sel});
    else n_pass++;
    n_total++;
    if (corr_lag !== 10'd184) $display("FAIL reset_lag: got %0d required 184", corr_lag);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (sc[i] !== MOST_NEG) $display("FAIL reset_score%0d: got %0h required %0h", i, sc[i], MOST_NEG);
      else n_pass++;
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_normal(input string nm);
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (got_sel[i] !== 3'(i) || got_lag[i] !== 10'(exp_lag[i]) || start_cyc[i] !== 1 + 4 * i)
        $display("FAIL %s_req%0d: got sel=%0d lag=%0d cyc=%0d required sel=%0d lag=%0d cyc=%0d",
                 nm, i, got_sel[i], got_lag[i], start_cyc[i], i, exp_lag[i], 1 + 4 * i);
      else n_pass++;
    end
    n_total++;
    if (n_valid !== 1 || valid_cyc !== 21 || n_start !== 5)
      $display("FAIL %s_valid: got pulses=%0d cyc=%0d starts=%0d required 1/21/5", nm, n_valid, valid_cyc, n_start);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (sc[i] !== resp_val[i]) $display("FAIL %s_score%0d: got %0d required %0d", nm, i, sc[i], resp_val[i]);
      else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s_busy_end: got %b required 0", nm, busy);
    else n_pass++;
  endtask

  task automatic test_scan;
    set_resp(100, 200, 300, -5, 50);
    resp_dly = 3; ofs_at = -1; coinc = 0;
    run_frame();
    test_normal("scan");
    n_total++;
    if (n_ovr !== 0) $display("FAIL scan_no_overrun: got %0d pulses required 0", n_ovr);
    else n_pass++;
  endtask

  task automatic test_ignored_done;
    corr_done = 1'b1; corr_result = 36'sd999;
    tick();
    corr_done = 1'b0; corr_result = '0;
    tick();
    n_total++;
    if (score_c !== 36'sd100 || score_a !== 36'sd50 || busy !== 1'b0 || scores_valid !== 1'b0)
      $display("FAIL idle_done: got c=%0d a=%0d busy=%b valid=%b required 100/50/0/0",
               score_c, score_a, busy, scores_valid);
    else n_pass++;
    set_resp(1, 2, 3, 4, 5);
    resp_dly = 3; ofs_at = -1; coinc = 1;
    run_frame();
    coinc = 0;
    test_normal("coinc");
  endtask

  task automatic test_timeout;
    n_total++;
    if (timeout_flag !== 1'b0) $display("FAIL pre_timeout_flag: got %b required 0", timeout_flag);
    else n_pass++;
    resp_dly = 0; ofs_at = -1; coinc = 0;
    run_frame();
    n_total++;
    if (start_cyc[1] !== 4097 || valid_cyc !== 20481 || n_valid !== 1)
      $display("FAIL timeout_timing: got start1=%0d valid=%0d pulses=%0d required 4097/20481/1",
               start_cyc[1], valid_cyc, n_valid);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (sc[i] !== MOST_NEG) $display("FAIL timeout_score%0d: got %0h required %0h", i, sc[i], MOST_NEG);
      else n_pass++;
    end
    n_total++;
    if (timeout_flag !== 1'b1) $display("FAIL timeout_flag: got %b required 1", timeout_flag);
    else n_pass++;
  endtask

  task automatic test_overrun;
    set_resp(100, 200, 300, -5, 50);
    resp_dly = 3; ofs_at = 4; coinc = 0;
    run_frame();
    ofs_at = -1;
    n_total++;
    if (n_ovr !== 1 || ovr_cyc !== 5) $display("FAIL overrun_pulse: got %0d pulses at %0d required 1 at 5", n_ovr, ovr_cyc);
    else n_pass++;
    test_normal("overrun");
  endtask

  task automatic test_reset_mid_scan;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    corr_done = 1'b1; corr_result = 36'sd11;
    tick();
    corr_done = 1'b0;
    tick();
    corr_done = 1'b1; corr_result = 36'sd22;
    tick();
    corr_done = 1'b0;
    tick();
    n_total++;
    if (corr_sel !== 3'd2 || busy !== 1'b1 || score_c !== 36'sd11)
      $display("FAIL mid_wait_e: got sel=%0d busy=%b c=%0d required 2/1/11", corr_sel, busy, score_c);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({corr_start, scores_valid, busy, frame_overrun, timeout_flag, corr_sel} !== 8'd0 || corr_lag !== 10'd184)
      $display("FAIL midrst_ctrl: got %b lag=%0d required 00000000 lag=184",
               {corr_start, scores_valid, busy, frame_overrun, timeout_flag, corr_sel}, corr_lag);
    else n_pass++;
    n_total++;
    if (score_c !== MOST_NEG || score_d !== MOST_NEG) $display("FAIL midrst_scores: got c=%0h d=%0h required %0h", score_c, score_d, MOST_NEG);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    set_resp(100, 200, 300, -5, 50);
    resp_dly = 3; ofs_at = -1; coinc = 0;
    run_frame();
    test_normal("restart");
  endtask

  task automatic test_done_vs_timeout;
    set_resp(-7, 8, -9, 10, -11);
    resp_dly = 4095; ofs_at = -1; coinc = 0;
    run_frame();
    n_total++;
    if (valid_cyc !== 20481) $display("FAIL race_timing: got valid at %0d required 20481", valid_cyc);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (sc[i] !== resp_val[i]) $display("FAIL race_score%0d: got %0d required %0d", i, sc[i], resp_val[i]);
      else n_pass++;
    end
    n_total++;
    if (timeout_flag !== 1'b0) $display("FAIL race_flag: got %b required 0", timeout_flag);
    else n_pass++;
  endtask

  task automatic test_two_frames;
    logic signed [35:0] exp_mid_c;
    set_resp(7, 7, 7, 7, 7);
    resp_dly = 1; ofs_at = -1; coinc = 0;
    run_frame();
    n_total++;
    if (score_c !== 36'sd7 || score_a !== 36'sd7) $display("FAIL frame1: got c=%0d a=%0d required 7/7", score_c, score_a);
    else n_pass++;
    set_resp(9, 9, 9, 9, 9);
    run_frame();
`ifdef NOTE_SCAN_HOLD_EN
    exp_mid_c = 36'sd7;
`else
    exp_mid_c = 36'sd9;
`endif
    n_total++;
    if (mid_c !== exp_mid_c || mid_a !== 36'sd7)
      $display("FAIL frame2_mid: got c=%0d a=%0d required %0d/7", mid_c, mid_a, exp_mid_c);
    else n_pass++;
    n_total++;
    if (valid_cyc !== 11) $display("FAIL frame2_min_latency: got valid at %0d required 11", valid_cyc);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (sc[i] !== 36'sd9) $display("FAIL frame2_score%0d: got %0d required 9", i, sc[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_ignored_done();
    test_timeout();
    test_overrun();
    test_reset_mid_scan();
    test_done_vs_timeout();
    test_two_frames();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
